csr_mmode: RTL and testbench
============================

Name: csr_mmode

Overview:
- Parametrised successor to the core's basic machine CSR file.
- Adds writable machine trap CSRs (mstatus MIE/MPIE, mscratch, mepc, mcause, mtval), a mtvec with direct/vectored mode, and mcycle/minstret counters with an inhibit register.
- Performs trap-entry and MRET state updates and produces the redirect PC.
- Sits in the execute/writeback stage next to the pipeline controller.

Parameters:
- ISA_M, 0, reports M in misa bit 12.
- ISA_C, 0, reports C in misa bit 2.
- ISA_F, 0, reports F in misa bit 5.
- COUNTER_W, 64, width of mcycle/minstret; legal range 32..64. Bits above COUNTER_W read 0; mcycleh/minstreth are illegal when COUNTER_W == 32.
- VECTORED_EN, 1, when 0, mtvec.MODE is hardwired to 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- csr_access_i  in  1  CSR instruction valid this cycle
- csr_addr_i  in  12  CSR address (csr_addr_t)
- csr_op_i  in  2  csr_operation_t: WRITE/SET/CLEAR/READ
- csr_wdata_i  in  32  rs1/uimm operand
- csr_rdata_o  out  32  old CSR value, combinational
- csr_illegal_o  out  1  access is illegal, combinational
- hartid_i  in  32  mhartid value
- mtvec_i  in  24  boot mtvec base bits [31:8]
- instr_ret_i  in  1  one instruction retired
- trap_i  in  1  take trap this cycle
- trap_cause_i  in  32  mcause value; bit 31 = interrupt
- trap_pc_i  in  32  PC of trapping instruction
- trap_tval_i  in  32  mtval value
- mret_i  in  1  MRET retiring
- trap_target_o  out  32  redirect PC for trap_i/mret_i, combinational
- mtvec_o  out  32  current mtvec
- mepc_o  out  32  current mepc
- mie_o  out  1  mstatus.MIE

Behaviour:
- Reset (rst_i high, async):
  - mstatus MIE=0, MPIE=0; mscratch=0, mepc=0, mcause=0, mtval=0, mtvec=0.
  - Counters 0; mcountinhibit=0; boot_load=1.
  - Outputs follow these values.
- mtvec boot load:
  - On the first clock edge with rst_i low, mtvec <= {mtvec_i, 8'h00} and boot_load clears.
  - Reads in that cycle return 0.
  - A CSR write to mtvec in that same cycle wins over the boot load.
- Read-only CSRs: misa = {2'b01, 4'b0, 13'b0, ISA_M, 6'h04, ISA_F, 2'b0, ISA_C, 2'b0} (bit 8 = I); mvendorid/marchid/mimpid = 0; mhartid = hartid_i.
- mstatus read: MIE at bit 3, MPIE at bit 7, MPP at bits 12:11 hardwired 2'b11; all other bits 0.
- Write data: WRITE = wdata; SET = rdata|wdata; CLEAR = rdata&~wdata.
- Write enable: wen = csr_access_i & ~csr_illegal_o & (op != READ) & ~trap_i. The CSR is updated at the next edge.
- Illegal access: any of the following; an illegal access has no state change and csr_rdata_o=0.
  - Unimplemented address.
  - op != READ to addr[11:10]==2'b11.
  - mcycleh/minstreth when COUNTER_W==32.
- WARL rules:
  - mepc bit 0 written 0; bit 1 written 0 when ISA_C==0.
  - mtvec bit 1 written 0; bit 0 written 0 if VECTORED_EN==0.
  - mcountinhibit keeps only bits 0 (CY) and 2 (IR).
- Counters:
  - mcycle increments every cycle unless CY is set.
  - minstret increments on instr_ret_i unless IR is set.
  - Both wrap modulo 2^COUNTER_W.
  - A CSR write to the low or high half replaces that half; the write wins over the same-cycle increment, and the other half is unchanged.
- Trap entry on trap_i=1 (next edge):
  - mepc <= trap_pc_i with bit 0 cleared; mcause <= trap_cause_i; mtval <= trap_tval_i.
  - MPIE <= MIE; MIE <= 0.
- trap_target_o:
  - Trap: {mtvec[31:2],2'b00}.
  - If mtvec[0]=1 and trap_cause_i[31]=1: base + 4*trap_cause_i[4:0].
  - mret_i: mepc.
  - Otherwise 0.
- MRET on mret_i=1 (next edge): MIE <= MPIE; MPIE <= 1.
- Priority:
  - trap_i > mret_i > CSR write for mstatus/mepc/mcause/mtval.
  - trap_i suppresses all CSR writes that cycle.
  - mret_i with a simultaneous CSR write to mstatus: MRET effect wins, other CSR writes proceed.
- Reset mid-operation: all state returns to reset values immediately; boot load repeats after release.

Decomposition:
- core_pkg additions:
  - csr_addr_t entries: MSCRATCH 0x340, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343, MCOUNTINHIBIT 0x320, MCYCLE 0xB00, MINSTRET 0xB02, MCYCLEH 0xB80, MINSTRETH 0xB82.
  - mstatus_t reuse.
  - mtvec_mode_t (DIRECT=0, VECTORED=1).
  - Cause constants.
- Sub-module csr_counter (COUNTER_W, inc_i, inhibit_i, wr_lo_i, wr_hi_i, wdata_i, count_o), instantiated for mcycle and minstret.

Test Plan:
- Reset release with mtvec_i=24'h000100, read mtvec on cycle 0 then cycle 1 -> 0x0, then 0x00010000; mtvec_o matches.
- SET mstatus 0x8 -> mie_o=1. trap_i with cause 0x2, pc 0x80000104 -> next cycle mepc=0x80000104, mcause=0x2, MIE=0, MPIE=1, trap_target_o=0x00010000. mret_i -> MIE=1, target=0x80000104.
- mtvec WRITE 0x00010001 then trap cause 0x80000007 -> trap_target_o=0x0001001C. With VECTORED_EN=0, the same sequence gives mtvec read 0x00010000 and target 0x00010000.
- COUNTER_W=64:
  - Write mcycle=0xFFFFFFFF, mcycleh=0 -> after 1 more cycle mcycleh reads 1, mcycle reads 0.
  - Set mcountinhibit=0x5 -> mcycle/minstret frozen across 10 cycles with instr_ret_i=1.
- WRITE to misa (0x301 is legal-ignored? no: 0xF11 mvendorid) -> csr_illegal_o=1, no state change. Access 0x7C0 -> illegal, rdata 0. COUNTER_W=32 read of 0xB80 -> illegal.
- WRITE mscratch=0xDEADBEEF in the same cycle as trap_i -> mscratch unchanged (0). CLEAR mscratch 0x0F after a write of 0xFF -> reads 0xF0.

Source files
------------

// File: rtl/csr_mmode_pkg.sv
// Shared types and constants for the machine-mode CSR file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csr_mmode_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS       = 12'h300,
        CSR_MISA          = 12'h301,
        CSR_MTVEC         = 12'h305,
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MSCRATCH      = 12'h340,
        CSR_MEPC          = 12'h341,
        CSR_MCAUSE        = 12'h342,
        CSR_MTVAL         = 12'h343,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_MVENDORID     = 12'hF11,
        CSR_MARCHID       = 12'hF12,
        CSR_MIMPID        = 12'hF13,
        CSR_MHARTID       = 12'hF14
    } csr_addr_t;

    typedef enum logic [1:0] {
        CSR_OP_WRITE = 2'd0,
        CSR_OP_SET   = 2'd1,
        CSR_OP_CLEAR = 2'd2,
        CSR_OP_READ  = 2'd3
    } csr_operation_t;

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    typedef enum logic {
        MTVEC_DIRECT   = 1'b0,
        MTVEC_VECTORED = 1'b1
    } mtvec_mode_t;

    localparam logic [31:0] CAUSE_INSTR_ILLEGAL = 32'h0000_0002;
    localparam logic [31:0] CAUSE_BREAKPOINT    = 32'h0000_0003;
    localparam logic [31:0] CAUSE_ECALL_M       = 32'h0000_000B;
    localparam logic [31:0] CAUSE_IRQ_SW_M      = 32'h8000_0003;
    localparam logic [31:0] CAUSE_IRQ_TIMER_M   = 32'h8000_0007;
    localparam logic [31:0] CAUSE_IRQ_EXT_M     = 32'h8000_000B;

    // MPP is fixed at M-mode since no lower privilege levels exist.
    function automatic logic [31:0] mstatus_rd(mstatus_t s);
        return {19'b0, 2'b11, 3'b0, s.mpie, 3'b0, s.mie, 3'b0};
    endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running performance counter with inhibit and split 32-bit halves writes.
// Latency: writes and increments land at the next clock edge.
// Backpressure: none; a half write overrides the same-cycle increment.
module csr_counter #(
    parameter int COUNTER_W = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        inhibit_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [COUNTER_W-1:0] cnt_q, cnt_d;
    logic [63:0]          cur, nxt;

    always_comb begin
        cur = 64'(cnt_q);
        nxt = cur;
        // A write freezes the untouched half: no carry from a dropped increment.
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) nxt[31:0]  = wdata_i;
            if (wr_hi_i) nxt[63:32] = wdata_i;
        end else if (inc_i && !inhibit_i) begin
            nxt = cur + 64'd1;
        end
        cnt_d = nxt[COUNTER_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count_o = 64'(cnt_q);

endmodule

// File: rtl/csr_mmode.sv
// Machine-mode CSR file: trap CSRs, mtvec, counters, trap entry / MRET redirect.
// Latency: reads combinational; writes and trap/MRET updates at the next edge.
// Backpressure: none; trap_i squashes the same-cycle CSR write.
module csr_mmode
    import csr_mmode_pkg::*;
#(
    parameter int ISA_M       = 0,
    parameter int ISA_C       = 0,
    parameter int ISA_F       = 0,
    parameter int COUNTER_W   = 64,
    parameter int VECTORED_EN = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_access_i,
    input  logic [11:0] csr_addr_i,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic [31:0] hartid_i,
    input  logic [23:0] mtvec_i,
    input  logic        instr_ret_i,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    output logic [31:0] trap_target_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    localparam logic HAS_M   = (ISA_M != 0);
    localparam logic HAS_C   = (ISA_C != 0);
    localparam logic HAS_F   = (ISA_F != 0);
    localparam logic HAS_VEC = (VECTORED_EN != 0);
    localparam logic HAS_HI  = (COUNTER_W > 32);
    localparam logic [31:0] MISA_VAL =
        {2'b01, 4'b0, 13'b0, HAS_M, 6'h04, HAS_F, 2'b0, HAS_C, 2'b0};

    mstatus_t    mstatus_q, mstatus_d;
    logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d, mtvec_q, mtvec_d;
    logic        cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d, boot_load_q, boot_load_d;

    logic [63:0] mcycle, minstret;
    logic [31:0] rdata, wdata;
    logic        legal, wen;
    logic        we_mstatus, we_mtvec, we_minh, we_mscratch, we_mepc, we_mcause, we_mtval;
    logic        we_mcycle, we_mcycleh, we_minstret, we_minstreth;
    logic [31:0] tvec_base;

    always_comb begin
        rdata = 32'h0;
        legal = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS:       rdata = mstatus_rd(mstatus_q);
            CSR_MISA:          rdata = MISA_VAL;
            CSR_MTVEC:         rdata = mtvec_q;
            CSR_MCOUNTINHIBIT: rdata = {29'b0, ir_inh_q, 1'b0, cy_inh_q};
            CSR_MSCRATCH:      rdata = mscratch_q;
            CSR_MEPC:          rdata = mepc_q;
            CSR_MCAUSE:        rdata = mcause_q;
            CSR_MTVAL:         rdata = mtval_q;
            CSR_MCYCLE:        rdata = mcycle[31:0];
            CSR_MINSTRET:      rdata = minstret[31:0];
            CSR_MCYCLEH:       begin rdata = mcycle[63:32];   legal = HAS_HI; end
            CSR_MINSTRETH:     begin rdata = minstret[63:32]; legal = HAS_HI; end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = 32'h0;
            CSR_MHARTID:       rdata = hartid_i;
            default:           legal = 1'b0;
        endcase

        csr_illegal_o = csr_access_i &&
            (!legal || (csr_op_i != CSR_OP_READ && csr_addr_i[11:10] == 2'b11));
        csr_rdata_o   = csr_illegal_o ? 32'h0 : rdata;

        case (csr_op_i)
            CSR_OP_WRITE: wdata = csr_wdata_i;
            CSR_OP_SET:   wdata = rdata | csr_wdata_i;
            CSR_OP_CLEAR: wdata = rdata & ~csr_wdata_i;
            default:      wdata = rdata;
        endcase

        wen          = csr_access_i && !csr_illegal_o && csr_op_i != CSR_OP_READ && !trap_i;
        we_mstatus   = wen && csr_addr_i == CSR_MSTATUS;
        we_mtvec     = wen && csr_addr_i == CSR_MTVEC;
        we_minh      = wen && csr_addr_i == CSR_MCOUNTINHIBIT;
        we_mscratch  = wen && csr_addr_i == CSR_MSCRATCH;
        we_mepc      = wen && csr_addr_i == CSR_MEPC;
        we_mcause    = wen && csr_addr_i == CSR_MCAUSE;
        we_mtval     = wen && csr_addr_i == CSR_MTVAL;
        we_mcycle    = wen && csr_addr_i == CSR_MCYCLE;
        we_mcycleh   = wen && csr_addr_i == CSR_MCYCLEH;
        we_minstret  = wen && csr_addr_i == CSR_MINSTRET;
        we_minstreth = wen && csr_addr_i == CSR_MINSTRETH;
    end

    always_comb begin
        mstatus_d   = mstatus_q;
        mscratch_d  = we_mscratch ? wdata : mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        mtvec_d     = mtvec_q;
        cy_inh_d    = we_minh ? wdata[0] : cy_inh_q;
        ir_inh_d    = we_minh ? wdata[2] : ir_inh_q;
        boot_load_d = 1'b0;

        if (trap_i) begin
            mstatus_d.mpie = mstatus_q.mie;
            mstatus_d.mie  = 1'b0;
            mepc_d         = {trap_pc_i[31:1], 1'b0};
            mcause_d       = trap_cause_i;
            mtval_d        = trap_tval_i;
        end else begin
            if (mret_i) begin
                mstatus_d.mie  = mstatus_q.mpie;
                mstatus_d.mpie = 1'b1;
            end else if (we_mstatus) begin
                mstatus_d.mie  = wdata[3];
                mstatus_d.mpie = wdata[7];
            end
            if (we_mepc)   mepc_d   = {wdata[31:2], wdata[1] & HAS_C, 1'b0};
            if (we_mcause) mcause_d = wdata;
            if (we_mtval)  mtval_d  = wdata;
        end

        // Software write to mtvec outranks the one-shot boot load.
        if (we_mtvec)         mtvec_d = {wdata[31:2], 1'b0, wdata[0] & HAS_VEC};
        else if (boot_load_q) mtvec_d = {mtvec_i, 8'h00};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_q   <= '0;
            mscratch_q  <= 32'h0;
            mepc_q      <= 32'h0;
            mcause_q    <= 32'h0;
            mtval_q     <= 32'h0;
            mtvec_q     <= 32'h0;
            cy_inh_q    <= 1'b0;
            ir_inh_q    <= 1'b0;
            boot_load_q <= 1'b1;
        end else begin
            mstatus_q   <= mstatus_d;
            mscratch_q  <= mscratch_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            mtvec_q     <= mtvec_d;
            cy_inh_q    <= cy_inh_d;
            ir_inh_q    <= ir_inh_d;
            boot_load_q <= boot_load_d;
        end
    end

    csr_counter #(.COUNTER_W(COUNTER_W)) u_mcycle (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(1'b1), .inhibit_i(cy_inh_q),
        .wr_lo_i(we_mcycle), .wr_hi_i(we_mcycleh), .wdata_i(wdata), .count_o(mcycle)
    );

    csr_counter #(.COUNTER_W(COUNTER_W)) u_minstret (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(instr_ret_i), .inhibit_i(ir_inh_q),
        .wr_lo_i(we_minstret), .wr_hi_i(we_minstreth), .wdata_i(wdata), .count_o(minstret)
    );

    assign tvec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        trap_target_o = 32'h0;
        if (trap_i) begin
            if (mtvec_mode_t'(mtvec_q[0]) == MTVEC_VECTORED && trap_cause_i[31])
                trap_target_o = tvec_base + {25'd0, trap_cause_i[4:0], 2'b00};
            else
                trap_target_o = tvec_base;
        end else if (mret_i) begin
            trap_target_o = mepc_q;
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mstatus_q.mie;

endmodule

// File: tb/tb_csr_mmode.sv
// Directed checks of csr_mmode; instance a uses defaults, instance b uses
// COUNTER_W=32, VECTORED_EN=0, ISA_M=1, ISA_C=1 with the same stimulus.
module tb_csr_mmode;

    logic        clk = 1'b0;
    logic        rst;
    logic        access;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdat;
    logic [31:0] hartid;
    logic [23:0] boot_tvec;
    logic        instr_ret, trap, mret;
    logic [31:0] cause, tpc, tval;

    logic [31:0] rdata_a, tgt_a, mtvec_a, mepc_a;
    logic        ill_a, mie_a;
    logic [31:0] rdata_b, tgt_b, mtvec_b, mepc_b;
    logic        ill_b, mie_b;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] OP_W = 2'd0, OP_S = 2'd1, OP_C = 2'd2, OP_R = 2'd3;

    always #5 clk = ~clk;

    csr_mmode dut_a (
        .clk_i(clk), .rst_i(rst), .csr_access_i(access), .csr_addr_i(addr),
        .csr_op_i(op), .csr_wdata_i(wdat), .csr_rdata_o(rdata_a),
        .csr_illegal_o(ill_a), .hartid_i(hartid), .mtvec_i(boot_tvec),
        .instr_ret_i(instr_ret), .trap_i(trap), .trap_cause_i(cause),
        .trap_pc_i(tpc), .trap_tval_i(tval), .mret_i(mret),
        .trap_target_o(tgt_a), .mtvec_o(mtvec_a), .mepc_o(mepc_a), .mie_o(mie_a)
    );

    csr_mmode #(.ISA_M(1), .ISA_C(1), .ISA_F(0), .COUNTER_W(32), .VECTORED_EN(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .csr_access_i(access), .csr_addr_i(addr),
        .csr_op_i(op), .csr_wdata_i(wdat), .csr_rdata_o(rdata_b),
        .csr_illegal_o(ill_b), .hartid_i(hartid), .mtvec_i(boot_tvec),
        .instr_ret_i(instr_ret), .trap_i(trap), .trap_cause_i(cause),
        .trap_pc_i(tpc), .trap_tval_i(tval), .mret_i(mret),
        .trap_target_o(tgt_b), .mtvec_o(mtvec_b), .mepc_o(mepc_b), .mie_o(mie_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        access = 1'b0; addr = 12'h0; op = OP_R; wdat = 32'h0;
        instr_ret = 1'b0; trap = 1'b0; mret = 1'b0;
    endtask

    task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
        access = 1'b1; op = o; addr = a; wdat = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; boot_tvec = 24'h000100; hartid = 32'h0000_0003;
        cause = 32'h0; tpc = 32'h0; tval = 32'h0;
        idle();
        cyc(); cyc();
        rst = 1'b0;
        csr(OP_R, 12'h305, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h0) begin n_err++; $display("FAIL boot_c0_read: got %h want %h", rdata_a, 32'h0); end
        n_vec++; if (mtvec_a !== 32'h0) begin n_err++; $display("FAIL boot_c0_mtvec_o: got %h want %h", mtvec_a, 32'h0); end
        n_vec++; if (mie_a !== 1'b0 || mepc_a !== 32'h0) begin n_err++; $display("FAIL reset_mie_mepc: got %b/%h want 0/0", mie_a, mepc_a); end
        cyc();
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h0001_0000) begin n_err++; $display("FAIL boot_c1_read: got %h want %h", rdata_a, 32'h0001_0000); end
        n_vec++; if (mtvec_a !== 32'h0001_0000) begin n_err++; $display("FAIL boot_c1_mtvec_o: got %h want %h", mtvec_a, 32'h0001_0000); end
        cyc();
    endtask

    task automatic test_readonly();
        csr(OP_R, 12'h301, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h4000_0100) begin n_err++; $display("FAIL misa_a: got %h want %h", rdata_a, 32'h4000_0100); end
        n_vec++; if (rdata_b !== 32'h4000_1104) begin n_err++; $display("FAIL misa_b: got %h want %h", rdata_b, 32'h4000_1104); end
        cyc();
        csr(OP_R, 12'hF14, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h0000_0003) begin n_err++; $display("FAIL mhartid: got %h want %h", rdata_a, 32'h3); end
        cyc();
    endtask

    task automatic test_trap_mret();
        csr(OP_S, 12'h300, 32'h8);
        cyc();
        csr(OP_R, 12'h300, 32'h0);
        @(negedge clk);
        n_vec++; if (mie_a !== 1'b1) begin n_err++; $display("FAIL set_mie: got %b want 1", mie_a); end
        n_vec++; if (rdata_a !== 32'h0000_1808) begin n_err++; $display("FAIL mstatus_rd: got %h want %h", rdata_a, 32'h1808); end
        cyc();
        idle(); trap = 1'b1; cause = 32'h2; tpc = 32'h8000_0104; tval = 32'h55;
        @(negedge clk);
        n_vec++; if (tgt_a !== 32'h0001_0000) begin n_err++; $display("FAIL trap_target: got %h want %h", tgt_a, 32'h0001_0000); end
        cyc();
        idle(); csr(OP_R, 12'h342, 32'h0);
        @(negedge clk);
        n_vec++; if (mepc_a !== 32'h8000_0104) begin n_err++; $display("FAIL trap_mepc: got %h want %h", mepc_a, 32'h8000_0104); end
        n_vec++; if (rdata_a !== 32'h2) begin n_err++; $display("FAIL trap_mcause: got %h want %h", rdata_a, 32'h2); end
        addr = 12'h300; #1;
        n_vec++; if (rdata_a !== 32'h0000_1880) begin n_err++; $display("FAIL trap_mstatus: got %h want %h", rdata_a, 32'h1880); end
        addr = 12'h343; #1;
        n_vec++; if (rdata_a !== 32'h55) begin n_err++; $display("FAIL trap_mtval: got %h want %h", rdata_a, 32'h55); end
        cyc();
        idle(); mret = 1'b1;
        @(negedge clk);
        n_vec++; if (tgt_a !== 32'h8000_0104) begin n_err++; $display("FAIL mret_target: got %h want %h", tgt_a, 32'h8000_0104); end
        cyc();
        idle(); csr(OP_R, 12'h300, 32'h0);
        @(negedge clk);
        n_vec++; if (mie_a !== 1'b1 || rdata_a !== 32'h0000_1888) begin n_err++; $display("FAIL mret_mstatus: got %b/%h want 1/%h", mie_a, rdata_a, 32'h1888); end
        cyc();
    endtask

    task automatic test_vectored();
        csr(OP_W, 12'h305, 32'h0001_0001);
        cyc();
        csr(OP_R, 12'h305, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h0001_0001) begin n_err++; $display("FAIL mtvec_vec_a: got %h want %h", rdata_a, 32'h0001_0001); end
        n_vec++; if (rdata_b !== 32'h0001_0000) begin n_err++; $display("FAIL mtvec_vec_b: got %h want %h", rdata_b, 32'h0001_0000); end
        cyc();
        idle(); trap = 1'b1; cause = 32'h8000_0007; tpc = 32'h8000_0201; tval = 32'h0;
        @(negedge clk);
        n_vec++; if (tgt_a !== 32'h0001_001C) begin n_err++; $display("FAIL vec_target_a: got %h want %h", tgt_a, 32'h0001_001C); end
        n_vec++; if (tgt_b !== 32'h0001_0000) begin n_err++; $display("FAIL vec_target_b: got %h want %h", tgt_b, 32'h0001_0000); end
        cyc();
        idle();
        @(negedge clk);
        n_vec++; if (mepc_a !== 32'h8000_0200) begin n_err++; $display("FAIL trap_pc_bit0: got %h want %h", mepc_a, 32'h8000_0200); end
        cyc();
    endtask

    task automatic test_mepc_warl();
        csr(OP_W, 12'h341, 32'h8000_0007);
        cyc();
        idle();
        @(negedge clk);
        n_vec++; if (mepc_a !== 32'h8000_0004) begin n_err++; $display("FAIL mepc_warl_a: got %h want %h", mepc_a, 32'h8000_0004); end
        n_vec++; if (mepc_b !== 32'h8000_0006) begin n_err++; $display("FAIL mepc_warl_b: got %h want %h", mepc_b, 32'h8000_0006); end
        cyc();
    endtask

    task automatic test_counter_wrap();
        csr(OP_W, 12'hB00, 32'hFFFF_FFFF);
        cyc();
        csr(OP_W, 12'hB80, 32'h0);
        cyc();
        csr(OP_R, 12'hB80, 32'h0);
        cyc();
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h1) begin n_err++; $display("FAIL mcycleh_carry: got %h want %h", rdata_a, 32'h1); end
        n_vec++; if (ill_a !== 1'b0 || ill_b !== 1'b1 || rdata_b !== 32'h0) begin n_err++; $display("FAIL mcycleh_legal: got %b/%b/%h want 0/1/0", ill_a, ill_b, rdata_b); end
        addr = 12'hB00; #1;
        n_vec++; if (rdata_a !== 32'h0) begin n_err++; $display("FAIL mcycle_wrap: got %h want %h", rdata_a, 32'h0); end
        cyc();
    endtask

    task automatic test_inhibit();
        csr(OP_W, 12'h320, 32'hFFFF_FFFF);
        cyc();
        csr(OP_R, 12'h320, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h5) begin n_err++; $display("FAIL minh_warl: got %h want %h", rdata_a, 32'h5); end
        cyc();
        csr(OP_W, 12'hB00, 32'h100);
        cyc();
        csr(OP_W, 12'hB02, 32'h200);
        cyc();
        idle(); instr_ret = 1'b1;
        repeat (10) cyc();
        csr(OP_R, 12'hB00, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h100) begin n_err++; $display("FAIL mcycle_frozen: got %h want %h", rdata_a, 32'h100); end
        addr = 12'hB02; #1;
        n_vec++; if (rdata_a !== 32'h200) begin n_err++; $display("FAIL minstret_frozen: got %h want %h", rdata_a, 32'h200); end
        cyc();
        csr(OP_W, 12'h320, 32'h0);
        cyc();
        idle(); instr_ret = 1'b1;
        repeat (3) cyc();
        idle(); csr(OP_R, 12'hB02, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h203) begin n_err++; $display("FAIL minstret_count: got %h want %h", rdata_a, 32'h203); end
        cyc();
    endtask

    task automatic test_illegal();
        csr(OP_W, 12'hF11, 32'h1234);
        @(negedge clk);
        n_vec++; if (ill_a !== 1'b1 || rdata_a !== 32'h0) begin n_err++; $display("FAIL write_ro: got %b/%h want 1/0", ill_a, rdata_a); end
        cyc();
        csr(OP_R, 12'h7C0, 32'h0);
        @(negedge clk);
        n_vec++; if (ill_a !== 1'b1 || rdata_a !== 32'h0) begin n_err++; $display("FAIL unimpl_addr: got %b/%h want 1/0", ill_a, rdata_a); end
        addr = 12'hF11; #1;
        n_vec++; if (ill_a !== 1'b0) begin n_err++; $display("FAIL read_ro_legal: got %b want 0", ill_a); end
        cyc();
    endtask

    task automatic test_back_to_back();
        csr(OP_W, 12'h340, 32'hDEAD_BEEF); trap = 1'b1; cause = 32'hB; tpc = 32'h8000_0300;
        cyc();
        idle(); csr(OP_R, 12'h340, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h0) begin n_err++; $display("FAIL trap_squash: got %h want %h", rdata_a, 32'h0); end
        cyc();
        csr(OP_W, 12'h340, 32'hFF);
        cyc();
        csr(OP_C, 12'h340, 32'h0F);
        cyc();
        csr(OP_R, 12'h340, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'hF0) begin n_err++; $display("FAIL mscratch_clear: got %h want %h", rdata_a, 32'hF0); end
        cyc();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; idle();
        #1;
        n_vec++; if (mtvec_a !== 32'h0 || mepc_a !== 32'h0 || mie_a !== 1'b0) begin n_err++; $display("FAIL async_reset: got %h/%h/%b want 0/0/0", mtvec_a, mepc_a, mie_a); end
        cyc();
        rst = 1'b0;
        csr(OP_W, 12'h305, 32'h0002_0000);
        cyc();
        csr(OP_R, 12'h305, 32'h0);
        @(negedge clk);
        n_vec++; if (rdata_a !== 32'h0002_0000 || rdata_b !== 32'h0002_0000) begin n_err++; $display("FAIL boot_write_wins: got %h/%h want %h", rdata_a, rdata_b, 32'h0002_0000); end
        addr = 12'h340; #1;
        n_vec++; if (rdata_a !== 32'h0) begin n_err++; $display("FAIL reset_mscratch: got %h want %h", rdata_a, 32'h0); end
        cyc();
        idle();
    endtask

    initial begin
        test_reset();
        test_readonly();
        test_trap_mret();
        test_vectored();
        test_mepc_warl();
        test_counter_wrap();
        test_inhibit();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
